// File: rtl/display_pkg.sv
// Shared constants for the 7-segment display path: active-low segment
// patterns ordered {g,f,e,d,c,b,a}, the anode-off value and digit slot indices.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Slot index equals the anode bit driven low for that digit.
    localparam logic [1:0] IDX_UNITS    = 2'd0;
    localparam logic [1:0] IDX_TENS     = 2'd1;
    localparam logic [1:0] IDX_HUNDREDS = 2'd2;
    localparam logic [1:0] IDX_SIGN     = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low segment pattern; non-BCD codes show "E".
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure table lookup; the default arm doubles as the 10..15 error glyph.
    always_comb begin
        // NOTE: default assigned first so every path drives seg and no latch is inferred.
        seg = SEG_E;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/seven_seg_driver.sv
// Time-multiplexed 4-digit common-anode driver: sign, hundreds, tens, units.
// Inputs are snapshotted once per scan so a frame never mixes two values.
module seven_seg_driver
    import display_pkg::*;
#(
    parameter int DIV_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_en,
    input  logic       negative,
    input  logic [3:0] bcd_hundreds,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_units,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [DIV_BITS-1:0] PRESCALE_ONE = 1;

    logic [DIV_BITS-1:0] prescaler;
    logic                tick;
    logic [1:0]          idx;
    logic                sh_negative;
    logic [3:0]          sh_hundreds;
    logic [3:0]          sh_tens;
    logic [3:0]          sh_units;
    logic [3:0]          mux_digit;
    logic [6:0]          dec_seg;
    logic                blank;
    logic [3:0]          an_next;
    logic [6:0]          seg_next;

    assign tick = &prescaler;

    // Free-running refresh prescaler; wraps naturally.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (reset) prescaler <= '0;
        else       prescaler <= prescaler + PRESCALE_ONE;
    end

    // Slot index advances once per prescaler wrap.
    always_ff @(posedge clk) begin
        if (reset)     idx <= IDX_UNITS;
        else if (tick) idx <= idx + 2'd1;
    end

    // Shadow capture on the sign-to-units transition, same edge idx returns to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_negative <= 1'b0;
            sh_hundreds <= '0;
            sh_tens     <= '0;
            sh_units    <= '0;
        end else if (tick && idx == IDX_SIGN) begin
            sh_negative <= negative;
            sh_hundreds <= bcd_hundreds;
            sh_tens     <= bcd_tens;
            sh_units    <= bcd_units;
        end
    end

    // Select the digit for the current slot and decide leading-zero blanking.
    always_comb begin
        mux_digit = sh_units;
        blank     = 1'b0;
        case (idx)
            IDX_UNITS:    mux_digit = sh_units;
            IDX_TENS: begin
                mux_digit = sh_tens;
                blank     = (sh_tens == 4'd0) && (sh_hundreds == 4'd0);
            end
            IDX_HUNDREDS: begin
                mux_digit = sh_hundreds;
                blank     = (sh_hundreds == 4'd0);
            end
            default:      blank = !sh_negative;
        endcase
    end

    bcd_to_7seg u_decode (
        .digit (mux_digit),
        .seg   (dec_seg)
    );

    // Apply blanking and the sign glyph after decode, then gate anodes by display_en.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        if (!blank) begin
            seg_next = (idx == IDX_SIGN) ? SEG_MINUS : dec_seg;
            an_next  = display_en ? ~(4'b0001 << idx) : AN_OFF;
        end
    end

    // Registered display outputs, one clock behind idx/shadow/display_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Self-checking bench for seven_seg_driver with DIV_BITS=2 (4-clock slots).
// A behavioural model pushes the expected {an,seg,dp} at each rising edge;
// the checker pops and compares on the following falling edge.
module tb_seven_seg_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_en = 1'b1;
    logic       negative = 1'b0;
    logic [3:0] bcd_hundreds = 4'd0;
    logic [3:0] bcd_tens = 4'd0;
    logic [3:0] bcd_units = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    seven_seg_driver #(.DIV_BITS(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .display_en   (display_en),
        .negative     (negative),
        .bcd_hundreds (bcd_hundreds),
        .bcd_tens     (bcd_tens),
        .bcd_units    (bcd_units),
        .an           (an),
        .seg          (seg),
        .dp           (dp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0000110;
        endcase
    endfunction

    // Reference model state (private to the model process).
    logic [1:0]  m_cnt = 2'd0;
    logic [1:0]  m_idx = 2'd0;
    logic        m_neg = 1'b0;
    logic [3:0]  m_h = 4'd0, m_t = 4'd0, m_u = 4'd0;

    always @(posedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       shown;
        if (reset) begin
            e_an = 4'b1111; e_seg = 7'b1111111;
            m_cnt = 2'd0; m_idx = 2'd0;
            m_neg = 1'b0; m_h = 4'd0; m_t = 4'd0; m_u = 4'd0;
        end else begin
            shown = 1'b1;
            e_seg = 7'b1111111;
            case (m_idx)
                2'd0: e_seg = pattern(m_u);
                2'd1: begin shown = (m_t != 0) || (m_h != 0); e_seg = pattern(m_t); end
                2'd2: begin shown = (m_h != 0); e_seg = pattern(m_h); end
                default: begin shown = m_neg; e_seg = 7'b0111111; end
            endcase
            if (!shown) begin
                e_an = 4'b1111; e_seg = 7'b1111111;
            end else begin
                e_an = 4'b1111;
                if (display_en) e_an[m_idx] = 1'b0;
            end
            if (m_cnt == 2'd3) begin
                if (m_idx == 2'd3) begin
                    m_neg = negative; m_h = bcd_hundreds; m_t = bcd_tens; m_u = bcd_units;
                end
                m_idx = m_idx + 2'd1;
            end
            m_cnt = m_cnt + 2'd1;
        end
        exp_q.push_back({e_an, e_seg, 1'b1});
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("scoreboard", {20'd0, an, seg, dp}, {20'd0, exp_q.pop_front()});
    end

    task automatic drive(input logic n, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        negative = n; bcd_hundreds = h; bcd_tens = t; bcd_units = u;
    endtask

    task automatic wait_an(input logic [3:0] target, input string tag);
        int n = 0;
        @(negedge clk);
        while (an !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an !== target) check({tag, "_timeout"}, {28'd0, an}, {28'd0, target});
    endtask

    task automatic expect_slot(input logic [3:0] target, input logic [6:0] s, input string tag);
        wait_an(target, tag);
        check(tag, {25'd0, seg}, {25'd0, s});
    endtask

    initial begin
        // Reset held for three clocks; outputs must be off throughout.
        repeat (3) begin
            @(negedge clk);
            check("rst_an", {28'd0, an}, 32'hF);
            check("rst_seg", {25'd0, seg}, 32'h7F);
            check("rst_dp", {31'd0, dp}, 32'd1);
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_an", {28'd0, an}, 32'hE);
        check("post_rst_seg", {25'd0, seg}, 32'h40);

        // -128
        drive(1'b1, 4'd1, 4'd2, 4'd8);
        repeat (20) @(negedge clk);
        expect_slot(4'b1110, 7'b0000000, "m128_units");
        expect_slot(4'b1101, 7'b0100100, "m128_tens");
        expect_slot(4'b1011, 7'b1111001, "m128_hund");
        expect_slot(4'b0111, 7'b0111111, "m128_sign");

        // +5
        drive(1'b0, 4'd0, 4'd0, 4'd5);
        repeat (20) @(negedge clk);
        expect_slot(4'b1110, 7'b0010010, "p5_units");

        // -7, then +105 driven during the tens slot
        drive(1'b1, 4'd0, 4'd0, 4'd7);
        repeat (20) @(negedge clk);
        expect_slot(4'b1110, 7'b1111000, "m7_units");
        begin
            int n = 0;
            while (an === 4'b1110 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("m7_tens_blank", {28'd0, an}, 32'hF);
        end
        drive(1'b0, 4'd1, 4'd0, 4'd5);
        expect_slot(4'b0111, 7'b0111111, "m7_sign_kept");
        expect_slot(4'b1110, 7'b0010010, "p105_units");
        expect_slot(4'b1101, 7'b1000000, "p105_tens");
        expect_slot(4'b1011, 7'b1111001, "p105_hund");

        // display_en low for a full frame, then resume
        @(negedge clk);
        display_en = 1'b0;
        @(negedge clk);
        repeat (16) begin
            @(negedge clk);
            check("dis_an", {28'd0, an}, 32'hF);
        end
        display_en = 1'b1;
        repeat (8) @(negedge clk);

        // Reset during the hundreds slot while showing -128
        drive(1'b1, 4'd1, 4'd2, 4'd8);
        repeat (20) @(negedge clk);
        wait_an(4'b1011, "mid_hund");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_units_an", {28'd0, an}, 32'hE);
        check("mid_rst_units_seg", {25'd0, seg}, 32'h40);
        repeat (14) begin
            @(negedge clk);
            check("mid_rst_frame", {31'd0,
                  ((an === 4'hE && seg === 7'b1000000) || (an === 4'hF && seg === 7'h7F))}, 32'd1);
        end
        expect_slot(4'b0111, 7'b0111111, "mid_rst_recapture");
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_driver.md
# seven_seg_driver

Time-multiplexed driver for a 4-digit common-anode 7-segment display, placed directly downstream of `number_formatter`. It takes the sign flag and three BCD digits of a signed 8-bit result (-128..127) and scans them onto the display one digit at a time. Digit order, left to right, is sign, hundreds, tens, units. Inputs are captured once per full scan so a frame never mixes two values, leading zeros are blanked, and all display outputs are registered.

## Interface
- `DIV_BITS`, 17: width of the refresh prescaler. One digit slot lasts 2^DIV_BITS clocks (about 763 Hz per digit at 100 MHz).
- `clk`  in  1: system clock, all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `display_en`  in  1: 0 forces all anodes off; scanning and capture continue.
- `negative`  in  1: sign flag from `number_formatter`.
- `bcd_hundreds`  in  4: hundreds BCD digit.
- `bcd_tens`  in  4: tens BCD digit.
- `bcd_units`  in  4: units BCD digit.
- `an`  out  4: anodes, active-low. `an[0]` is units, `an[3]` is sign.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low, constant 1 (off).

## Operation
- **Prescaler:** free-running DIV_BITS-bit counter, wraps naturally. `tick` is asserted when the counter is all ones.
- **Digit index:** 2-bit `idx`, advances 0→1→2→3→0 on `tick`.
- **Shadow capture:** on a cycle where `tick`=1 and `idx`=3, the shadow registers load {negative, hundreds, tens, units}. Between captures, input changes are ignored.
- **Digit content** per `idx`, taken from the shadow registers:
  - 0: units, always shown (value 0 shows "0").
  - 1: tens, blanked when tens=0 and hundreds=0.
  - 2: hundreds, blanked when hundreds=0.
  - 3: "-" (seg=0111111) when negative, otherwise blanked.
- **Blanked slot:** `an`=1111, `seg`=1111111.
- **Decode:** 0..9 map to the standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10..15 show "E" (0000110), and blanking rules treat them as nonzero.
- **Active slot:** `an` has a single 0 at bit `idx`, unless `display_en`=0, in which case `an`=1111 and `seg` is unchanged.

## Timing
- **Reset** (synchronous; all outputs registered):
  - prescaler=0, `idx`=0, shadow=0.
  - `an`=1111, `seg`=1111111, `dp`=1.
- **Output latency:** `an`/`seg`/`dp` are recomputed every cycle from (`idx`, shadow, `display_en`), so they lag those by exactly 1 clock.
  - First cycle after reset deasserts: outputs still hold reset values.
  - Next cycle: `an`=1110, `seg`=1000000 (units "0").
- **Capture timing:** shadow and `idx`=0 update on the same edge. The first frame using new data therefore begins with its units slot.
- **Mid-scan input change:** invisible until the next `idx` 3→0 transition. Worst-case input-to-display latency is 4·2^DIV_BITS + 1 clocks.
- **Reset mid-scan:** reset takes effect at the next edge and overrides `tick` and capture. The shadow is cleared, so a pre-reset value is never displayed.
- **`display_en` change:** reflected on `an` 1 clock later, with no effect on `idx` or the prescaler.

## Structure
- **Shared package `display_pkg`:**
  - segment pattern constants SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK;
  - AN_OFF = 4'b1111;
  - digit-index localparams IDX_UNITS/TENS/HUNDREDS/SIGN.
- **Sub-module `bcd_to_7seg`:** one combinational instance that maps a 4-bit BCD digit to `seg`. The slot multiplexer selects its input, and blanking is applied after decode.

## Test plan
All scenarios use DIV_BITS=2, giving a 4-clock slot.
- **Reset:** hold `reset` for 3 clocks. Require `an`=1111, `seg`=1111111, `dp`=1 during reset and 1 clock after. Then require `an`=1110, `seg`=1000000.
- **-128** (neg=1, 1,2,8):
  - `an`=1110 → `seg` 0000000;
  - 1101 → 0100100;
  - 1011 → 1111001;
  - 0111 → 0111111.
- **+5** (neg=0, 0,0,5): `an`=1110 with `seg`=0010010. All other slots show `an`=1111, `seg`=1111111.
- **-7 then +105:** frame 1 shows units 7 (1111000), tens and hundreds blank, sign "-". Then drive +105 during the tens slot. The rest of that frame must still show -7. The next frame shows 5, 0 (tens not blanked), 1, and a blank sign.
- **`display_en`=0 for one full frame:** `an`=1111 throughout, with `idx` progression unchanged. Re-enabling resumes at the correct slot 1 clock later.
- **Reset asserted in the hundreds slot while showing -128:** after release, the first frame shows "0" on units only until the next capture loads the inputs.
